ram_bist_ctrl: RTL
==================

Name: ram_bist_ctrl

Overview:
Parametrised built-in self-test engine for a single-port synchronous RAM (block RAM IP or inferred). On start it writes a selectable pattern to every address, reads every address back and compares each word against the expected value. It reports busy/done/pass status and a saturating error count. It is the generalised successor of the fixed-width, fixed-pattern RAM write/read test, and sits between the RAM instance and board-level status (LEDs/ILA).

Parameters:
DATA_W, 16, RAM data width in bits (1..64)
ADDR_W, 8, RAM address width; depth = 2**ADDR_W
RD_LAT, 1, RAM read latency in cycles (1 or 2)
ERR_W, 16, error counter width

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a test run; ignored while busy=1
mode  in  2  pattern select, sampled only on accepted start
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the read address
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  1  result of last run; high when err_cnt==0; held until next start
err_cnt  out  ERR_W  mismatches in last/current run; saturates at all-ones

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, pass=0, err_cnt=0. The FSM goes to IDLE and the compare pipeline is flushed. Reset mid-run aborts with no done pulse.
- Pattern for address a, based on the latched mode:
  - 0: a, zero-extended or truncated to DATA_W
  - 1: bitwise inverse of mode 0
  - 2: checkerboard; 0x55.. for even a, 0xAA.. for odd a
  - 3: all ones
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches mode, clears err_cnt and pass, sets busy. Next cycle is WRITE with addr=0.
- WRITE: ram_we=1 and ram_wdata=pattern(addr) each cycle; addr increments. After addr=DEPTH-1, go to READ with addr=0. Exactly DEPTH write cycles.
- READ: ram_we=0; addr increments each cycle for DEPTH cycles. A valid flag and the expected word travel through an RD_LAT-deep shift register alongside the addresses.
- DRAIN: RD_LAT cycles to let the last reads return.
- Compare: when the delayed valid flag is 1 and ram_rdata != expected, err_cnt increments by 1 (saturating at 2**ERR_W-1).
- DONE: one cycle. done=1, busy drops to 0, pass=(err_cnt==0), including the compare from the final drain cycle. Then IDLE.
- Run length from the start cycle to the done cycle is 2*DEPTH + RD_LAT + 2 cycles.
- Address counter wraps to 0 at the WRITE->READ transition. No address outside 0..DEPTH-1 is ever driven.
- start during busy, or coincident with done, is ignored. A new start is accepted from the first IDLE cycle after DONE.

Optional Feature:
Macro RAM_BIST_ERR_LOG_EN.
- Defined: adds outputs first_err_addr (ADDR_W), first_err_exp (DATA_W) and first_err_got (DATA_W), plus flag first_err_vld (1).
  - Captured on the first mismatch of a run and held until the next accepted start or reset.
  - All are 0 after reset.
  - Later mismatches do not overwrite them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults with ADDR_W=4, RD_LAT=1, ideal RAM model, mode=0: expect 16 write cycles with wdata=0..15. done exactly 35 cycles after the start cycle, pass=1, err_cnt=0.
- Mode 2 with DATA_W=16: writes alternate 0x5555/0xAAAA. A model fault forcing bit0 stuck-at-1 on reads gives err_cnt=8, pass=0.
- RD_LAT=2, mode=1, ideal RAM: done 36 cycles after start with no errors. With a model that returns data one cycle early, err_cnt=16.
- ERR_W=3 with all 16 reads corrupted: err_cnt saturates at 7, pass=0. With RAM_BIST_ERR_LOG_EN defined, a single corruption at address 5 (mode 3) gives first_err_addr=5, first_err_exp=0xFFFF and first_err_got equal to the corrupted value.
- Assert rst for one cycle mid-READ: all outputs return to reset values immediately, no done pulse. A fresh start then completes normally with pass=1.
- Pulse start during WRITE and again on the done cycle: both are ignored, with a single done per run. A start on the following cycle begins a new run.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// RAM BIST engine: writes a pattern to every address, reads it back, counts mismatches.
// Define RAM_BIST_ERR_LOG_EN to add first-mismatch capture (address, expected, received).
module ram_bist_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1,
   parameter int ERR_W  = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt
`ifdef RAM_BIST_ERR_LOG_EN
   ,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [DATA_W-1:0] first_err_got,
   output logic              first_err_vld
`endif
);

   // state | meaning
   // IDLE  | waiting for start; pass/err_cnt hold the last result
   // WRITE | writing pattern(addr) to every address
   // READ  | issuing reads; expected words ride the compare pipe
   // DRAIN | RD_LAT cycles for the last reads to return
   // DONE  | one-cycle done pulse, pass updated
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        mode_q;
   logic [1:0]        drain_cnt;
   logic [RD_LAT-1:0] vld_pipe;
   logic [DATA_W-1:0] exp_pipe [RD_LAT];
   logic              addr_last;
   logic              mism;
   logic [ERR_W-1:0]  err_nxt;

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] p;
      p = '0;
      case (m)
         2'd0:    p = DATA_W'(a);
         2'd1:    p = ~DATA_W'(a);
         2'd2:    for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ ~i[0];
         default: p = '1;
      endcase
      return p;
   endfunction

   assign addr_last = &addr;
   assign ram_we    = (state == WRITE);
   assign ram_addr  = addr;
   assign ram_wdata = ram_we ? pattern(mode_q, addr) : '0;
   assign busy      = (state == WRITE) || (state == READ) || (state == DRAIN);
   assign done      = (state == DONE);

   assign mism    = vld_pipe[RD_LAT-1] && (ram_rdata != exp_pipe[RD_LAT-1]);
   assign err_nxt = (mism && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = WRITE;
         WRITE:   if (addr_last) state_nxt = READ;
         READ:    if (addr_last) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 2'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         addr      <= '0;
         mode_q    <= '0;
         drain_cnt <= '0;
         err_cnt   <= '0;
         pass      <= 1'b0;
      end else begin
         err_cnt <= err_nxt;
         case (state)
            IDLE: if (start) begin
               mode_q  <= mode;
               err_cnt <= '0;
               pass    <= 1'b0;
               addr    <= '0;
            end
            // address wraps to 0 on its own at the end of WRITE and READ
            WRITE, READ: begin
               addr      <= addr + ADDR_W'(1);
               drain_cnt <= 2'(RD_LAT - 1);
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - 2'd1;
               if (drain_cnt == 2'd0) pass <= (err_nxt == '0);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) exp_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= (state == READ);
         exp_pipe[0] <= pattern(mode_q, addr);
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
         end
      end
   end

`ifdef RAM_BIST_ERR_LOG_EN
   logic [ADDR_W-1:0] addr_pipe [RD_LAT];

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
         first_err_vld  <= 1'b0;
      end else begin
         addr_pipe[0] <= addr;
         for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
         if ((state == IDLE) && start) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            first_err_vld  <= 1'b0;
         end else if (mism && !first_err_vld) begin
            first_err_addr <= addr_pipe[RD_LAT-1];
            first_err_exp  <= exp_pipe[RD_LAT-1];
            first_err_got  <= ram_rdata;
            first_err_vld  <= 1'b1;
         end
      end
   end
`endif

endmodule
